// File: rtl/taus88_rng.sv
// Combined Tausworthe (taus88) uniform 32-bit RNG: three shift-register components
// advance every clock and the output is their XOR. Reseedable through seed/re_seed.
module taus88_rng #(
  parameter logic [31:0] S1_INIT = 32'd12345,
  parameter logic [31:0] S2_INIT = 32'd12345,
  parameter logic [31:0] S3_INIT = 32'd12345
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        re_seed,
  output logic [31:0] rnd
);

  logic [31:0] s1_q, s2_q, s3_q;
  logic [31:0] s1_d, s2_d, s3_d;
  logic [31:0] b1, b2, b3;
  logic        seed_ok;

  // Seeds 0 and 1 would lock S1 at zero, so they fall back to S1_INIT.
  assign seed_ok = |seed[31:1];

  always_comb begin
    b1   = ((s1_q << 13) ^ s1_q) >> 19;
    b2   = ((s2_q << 2)  ^ s2_q) >> 25;
    b3   = ((s3_q << 3)  ^ s3_q) >> 11;
    s1_d = ((s1_q & 32'hFFFF_FFFE) << 12) ^ b1;
    s2_d = ((s2_q & 32'hFFFF_FFF8) << 4)  ^ b2;
    s3_d = ((s3_q & 32'hFFFF_FFF0) << 17) ^ b3;
    if (re_seed) begin
      s1_d = seed_ok ? seed : S1_INIT;
      s2_d = S2_INIT;
      s3_d = S3_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= S1_INIT;
      s2_q <= S2_INIT;
      s3_q <= S3_INIT;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rnd = s1_q ^ s2_q ^ s3_q;

endmodule

// File: tb/tb_taus88_rng.sv
// Scoreboard bench for taus88_rng: a table-driven taus88 model predicts rnd; a monitor
// compares the DUT after every clock edge and after every asynchronous reset.
module tb_taus88_rng;

  localparam logic [31:0] P1 = 32'd2;
  localparam logic [31:0] P2 = 32'd8;
  localparam logic [31:0] P3 = 32'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        re_seed = 1'b0;
  logic [31:0] rnd;

  taus88_rng #(
    .S1_INIT(P1),
    .S2_INIT(P2),
    .S3_INIT(P3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seed   (seed),
    .re_seed(re_seed),
    .rnd    (rnd)
  );

  always #5 clk = ~clk;

  // Reference model: component state plus per-component taus88 constants.
  logic [31:0] m_s [3];
  int unsigned q_sh [3] = '{13, 2, 3};
  int unsigned s_sh [3] = '{19, 25, 11};
  int unsigned k_sh [3] = '{12, 4, 17};
  logic [31:0] m_mask [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFF0};

  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  event async_evt;

  function automatic logic [31:0] model_out();
    return m_s[0] ^ m_s[1] ^ m_s[2];
  endfunction

  task automatic model_init();
    m_s[0] = P1;
    m_s[1] = P2;
    m_s[2] = P3;
  endtask

  task automatic model_seed(input logic [31:0] sd);
    model_init();
    if (sd > 32'd1) m_s[0] = sd;
  endtask

  task automatic model_adv();
    logic [31:0] b;
    for (int i = 0; i < 3; i++) begin
      b = ((m_s[i] << q_sh[i]) ^ m_s[i]) >> s_sh[i];
      m_s[i] = ((m_s[i] & m_mask[i]) << k_sh[i]) ^ b;
    end
  endtask

  // Drive one cycle's inputs after the falling edge and predict rnd after the next rise.
  task automatic step(input bit r, input bit rs, input logic [31:0] sd,
                      input bit use_exp, input logic [31:0] exp_v);
    @(negedge clk);
    #1;
    rst = r;
    re_seed = rs;
    seed = sd;
    if (r) model_init();
    else if (rs) model_seed(sd);
    else model_adv();
    exp_q.push_back(use_exp ? exp_v : model_out());
  endtask

  // Assert rst between edges: rnd must change at once and hold across the next edge.
  task automatic async_rst(input bit rs, input logic [31:0] sd);
    @(negedge clk);
    #1;
    rst = 1'b1;
    re_seed = rs;
    seed = sd;
    model_init();
    exp_q.push_back(32'h0000_001A);
    exp_q.push_back(model_out());
    ->async_evt;
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk or async_evt);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rnd !== e) begin
          n_err++;
          $display("FAIL rnd vec %0d t=%0t: got %h expected %h", n_vec, $time, rnd, e);
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] sd;
    async_rst(1'b0, 32'h0);
    step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0020_2080);
    step(1'b0, 1'b0, 32'h1234_5678, 1'b1, 32'h0200_2C80);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, $urandom, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_2018);
    step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0220_0000);
    step(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_001A);
    step(1'b0, 1'b0, 32'h0,         1'b1, 32'h0020_2080);
    step(1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_001A);
    step(1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_001A);
    step(1'b0, 1'b0, 32'h0,         1'b1, 32'h0020_2080);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, $urandom, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_001A);
    step(1'b0, 1'b0, 32'h0,         1'b1, 32'h0020_2080);
    step(1'b0, 1'b0, 32'h0,         1'b1, 32'h0200_2C80);
    async_rst(1'b1, 32'h0000_2000);
    step(1'b0, 1'b0, 32'h0,         1'b1, 32'h0020_2080);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_rst(1'($urandom_range(0, 1)), $urandom);
      end else if (r < 4) begin
        step(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0);
      end else if (r < 12) begin
        sd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
        step(1'b0, 1'b1, sd, 1'b0, 32'h0);
      end else begin
        step(1'b0, 1'b0, $urandom, 1'b0, 32'h0);
      end
    end

    @(negedge clk);
    rst = 1'b0;
    re_seed = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
